uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
Receive-side command decoder. Sits behind the UART receiver and consumes its byte stream (rx_data qualified by a one-cycle rx_en pulse). Assembles fixed-length command frames from the host, checks them, and issues single-cycle register-write strobes to the video/target-tracking control logic. Also produces a one-byte ack/nak for the transmit path. It is the host-to-FPGA counterpart of the FPGA-to-host frame generator.

Parameters:
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYC, 6450, maximum clk cycles allowed between bytes inside a frame (10 bit-times at BPS_NUM 645).
ACK_OK, 8'h5A, ack byte for a good frame.
ACK_ERR, 8'hE1, nak byte for a checksum failure.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte; valid only when rx_en=1
rx_en  in  1  one-cycle strobe per received byte
wr_en  out  1  one-cycle register-write strobe
wr_addr  out  8  register address; held until the next write
wr_data  out  16  register data; held until the next write
ack_data  out  8  ack/nak byte for the transmitter
ack_valid  out  1  ack byte pending
ack_ready  in  1  transmitter accepts ack_data this cycle
frame_cnt  out  16  count of good frames; wraps from 0xFFFF to 0
err_cnt  out  8  count of checksum errors plus timeouts; saturates at 0xFF
timeout  out  1  one-cycle pulse when a frame is aborted by the gap timer

Behaviour:
- Reset is synchronous and active-high on clk. All outputs reset to 0. The FSM returns to IDLE and the gap counter clears. A frame in progress when reset asserts is discarded with no wr_en and no ack.
- Frame format: HEADER, ADDR, DHI, DLO, CSUM. CSUM = (ADDR + DHI + DLO) mod 256.
- FSM states: IDLE, ADDR, DHI, DLO, CSUM. A state advances only on rx_en.
  - IDLE: a byte equal to HEADER moves to ADDR. Any other byte is ignored silently, with no count and no ack.
  - ADDR, DHI, DLO: the byte is latched into internal shadow registers and the running 8-bit sum is updated. A byte equal to HEADER is treated as data, with no resync.
  - CSUM, on a match: wr_addr and wr_data update from the shadows and wr_en pulses high for exactly one cycle. This happens on the clk edge after the rx_en cycle (latency 1). frame_cnt increments, ack_data=ACK_OK, ack_valid=1, and the FSM returns to IDLE.
  - CSUM, on a mismatch: no wr_en, err_cnt increments (saturating), ack_data=ACK_ERR, ack_valid=1, and the FSM returns to IDLE.
- Gap timer:
  - Active only in states other than IDLE. It clears on every rx_en and counts otherwise.
  - When the count reaches TIMEOUT_CYC-1 without an rx_en, the FSM goes to IDLE, timeout pulses for one cycle and err_cnt increments. No ack is produced.
  - If rx_en arrives in the same cycle the limit is reached, rx_en wins: the byte is consumed and the counter clears.
- Ack handshake:
  - ack_valid stays high until a cycle in which ack_ready=1, then drops on the next edge.
  - A new ack arriving while one is pending overwrites ack_data (latest wins) and ack_valid stays 1.
  - A new ack in the same cycle as ack_ready=1: the new ack is kept pending and ack_valid stays 1.
- Back-to-back frames with no idle gap are accepted, including a HEADER byte in the cycle right after the CSUM byte.

Optional Feature:
UART_CMD_CHKSUM_EN
- Defined: the 5-byte frame with CSUM state and checksum check, as above.
- Undefined: 4-byte frame (HEADER, ADDR, DHI, DLO). The CSUM state and ACK_ERR path are removed. The write is issued one cycle after the DLO rx_en, and every completed frame is acked with ACK_OK. err_cnt counts timeouts only.

Test Plan:
- Bytes A5 03 12 34 49, with ack_ready=1 -> wr_en one cycle after the 5th rx_en; wr_addr=8'h03, wr_data=16'h1234; frame_cnt=1; ack_data=5A.
- Bytes A5 03 12 34 48 -> no wr_en; err_cnt=1; ack_data=E1; wr_addr and wr_data unchanged.
- Bytes 00 FF A5 10 00 01 11 -> the leading 00 and FF are ignored; one write with addr 10, data 0001; frame_cnt=1.
- Bytes A5 07, then no byte for 6450 cycles -> timeout pulses once; err_cnt=1; FSM in IDLE; the next frame A5 01 00 02 03 writes 0002 to addr 01.
- Two good frames back-to-back with ack_ready held 0 -> two wr_en pulses; one ack pending with 5A; asserting ack_ready for one cycle clears ack_valid.
- reset asserted for one cycle after A5 01 00 -> all outputs 0; a following 02 03 produces no write.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_rx_if                                                       |
// | Byte-stream input, register-write strobe, ack handshake and status   |
// | counters of the host command decoder.                                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_cmd_rx_if;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic        ack_ready;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        timeout;

  modport master (
    output rx_data, rx_en, ack_ready,
    input  wr_en, wr_addr, wr_data, ack_data, ack_valid, frame_cnt, err_cnt, timeout
  );

  modport slave (
    input  rx_data, rx_en, ack_ready,
    output wr_en, wr_addr, wr_data, ack_data, ack_valid, frame_cnt, err_cnt, timeout
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_rx                                                          |
// | Host command frame decoder: HEADER ADDR DHI DLO [CSUM] -> register   |
// | write strobe plus ack/nak byte. Checksum byte enabled by the macro   |
// | UART_CMD_CHKSUM_EN.                                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_cmd_rx #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 6450,
  parameter logic [7:0] ACK_OK      = 8'h5A
`ifdef UART_CMD_CHKSUM_EN
  ,
  parameter logic [7:0] ACK_ERR     = 8'hE1
`endif
) (
  input  logic         clk,
  input  logic         reset,
  uart_cmd_rx_if.slave bus
);

  localparam int               GAP_W   = $clog2(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3
`ifdef UART_CMD_CHKSUM_EN
    ,
    S_CSUM = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       addr_q, dhi_q;
  logic [15:0]      wdata;
  logic             do_write, do_timeout, ack_new, err_inc;
  logic [7:0]       ack_byte;

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] dlo_q, sum_q;
  logic       do_nak;

  assign ack_new  = do_write | do_nak;
  assign ack_byte = do_write ? ACK_OK : ACK_ERR;
  assign err_inc  = do_timeout | do_nak;
`else
  assign ack_new  = do_write;
  assign ack_byte = ACK_OK;
  assign err_inc  = do_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == S_IDLE || bus.rx_en || do_timeout) ? '0 : gap_q + 1'b1;
    end
  end

  // A byte always beats the gap limit: the timeout branch is only reached without rx_en.
  always_comb begin
    state_d    = state_q;
    do_write   = 1'b0;
    do_timeout = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    do_nak     = 1'b0;
    wdata      = {dhi_q, dlo_q};
`else
    wdata      = {dhi_q, bus.rx_data};
`endif
    if (bus.rx_en) begin
      case (state_q)
        S_IDLE: if (bus.rx_data == HEADER) state_d = S_ADDR;
        S_ADDR: state_d = S_DHI;
        S_DHI:  state_d = S_DLO;
`ifdef UART_CMD_CHKSUM_EN
        S_DLO:  state_d = S_CSUM;
        S_CSUM: begin
          state_d = S_IDLE;
          if (bus.rx_data == sum_q) do_write = 1'b1;
          else                      do_nak   = 1'b1;
        end
`else
        S_DLO: begin
          state_d  = S_IDLE;
          do_write = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && gap_q == GAP_MAX) begin
      state_d    = S_IDLE;
      do_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      dhi_q  <= '0;
`ifdef UART_CMD_CHKSUM_EN
      dlo_q  <= '0;
      sum_q  <= '0;
`endif
    end else if (bus.rx_en) begin
      case (state_q)
        S_ADDR: begin
          addr_q <= bus.rx_data;
`ifdef UART_CMD_CHKSUM_EN
          sum_q  <= bus.rx_data;
`endif
        end
        S_DHI: begin
          dhi_q <= bus.rx_data;
`ifdef UART_CMD_CHKSUM_EN
          sum_q <= sum_q + bus.rx_data;
`endif
        end
`ifdef UART_CMD_CHKSUM_EN
        S_DLO: begin
          dlo_q <= bus.rx_data;
          sum_q <= sum_q + bus.rx_data;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.ack_data  <= '0;
      bus.ack_valid <= 1'b0;
      bus.frame_cnt <= '0;
      bus.err_cnt   <= '0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.wr_en   <= do_write;
      bus.timeout <= do_timeout;
      if (do_write) begin
        bus.wr_addr   <= addr_q;
        bus.wr_data   <= wdata;
        bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
      if (err_inc && bus.err_cnt != 8'hFF)
        bus.err_cnt <= bus.err_cnt + 8'd1;
      // A fresh ack outranks a same-cycle accept of the old one.
      if (ack_new) begin
        bus.ack_valid <= 1'b1;
        bus.ack_data  <= ack_byte;
      end else if (bus.ack_ready) begin
        bus.ack_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_cmd_rx                                                       |
// | Directed table-driven bench for uart_cmd_rx (both frame formats).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_cmd_rx;

`ifdef UART_CMD_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_cmd_rx_if bus ();

  uart_cmd_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int wr_pulses = 0;
  int to_pulses = 0;

  always @(negedge clk) begin
    if (bus.wr_en)   wr_pulses++;
    if (bus.timeout) to_pulses++;
  end

  typedef struct {
    bit          junk;
    logic [7:0]  addr, dhi, dlo, csum;
    bit          good;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs [7];
  logic        exp_w;
  logic [7:0]  e_addr, e_ack;
  logic [15:0] e_data, e_frames;
  logic [7:0]  e_errs;
  int          n, w0, t0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic put(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_en   = 1'b1;
    @(negedge clk);
    bus.rx_en   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] cs);
    put(8'hA5);
    put(a);
    put(hi);
    put(lo);
    if (CHK) put(cs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'h03, 8'h12, 8'h34, 8'h49, 1'b1, 8'h03, 16'h1234};
    vecs[1] = '{1'b0, 8'h04, 8'h56, 8'h78, 8'hD3, 1'b0, 8'h04, 16'h5678};
    vecs[2] = '{1'b1, 8'h10, 8'h00, 8'h01, 8'h11, 1'b1, 8'h10, 16'h0001};
    vecs[3] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'hA5, 1'b1, 8'hA5, 16'h0000};
    vecs[4] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 1'b1, 8'hFF, 16'hFFFF};
    vecs[5] = '{1'b0, 8'h01, 8'h00, 8'h02, 8'h03, 1'b1, 8'h01, 16'h0002};
    vecs[6] = '{1'b0, 8'h20, 8'hAB, 8'hCD, 8'h00, 1'b0, 8'h20, 16'hABCD};

    reset = 1'b1;
    bus.rx_en = 1'b0;
    bus.rx_data = 8'h00;
    bus.ack_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr_en",     bus.wr_en, 0);
    check("rst_wr_addr",   bus.wr_addr, 0);
    check("rst_wr_data",   bus.wr_data, 0);
    check("rst_ack_data",  bus.ack_data, 0);
    check("rst_ack_valid", bus.ack_valid, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_err_cnt",   bus.err_cnt, 0);
    check("rst_timeout",   bus.timeout, 0);

    e_addr = 8'h00; e_data = 16'h0000; e_frames = 16'd0; e_errs = 8'd0;

    for (int i = 0; i < 7; i++) begin
      exp_w = CHK ? vecs[i].good : 1'b1;
      if (vecs[i].junk) begin
        put(8'h00);
        put(8'hFF);
      end
      send_frame(vecs[i].addr, vecs[i].dhi, vecs[i].dlo, vecs[i].csum);
      if (exp_w) begin
        e_addr = vecs[i].exp_addr;
        e_data = vecs[i].exp_data;
        e_frames++;
        e_ack = 8'h5A;
      end else begin
        e_errs++;
        e_ack = 8'hE1;
      end
      check($sformatf("v%0d_wr_en", i),     bus.wr_en, exp_w);
      check($sformatf("v%0d_wr_addr", i),   bus.wr_addr, e_addr);
      check($sformatf("v%0d_wr_data", i),   bus.wr_data, e_data);
      check($sformatf("v%0d_frame_cnt", i), bus.frame_cnt, e_frames);
      check($sformatf("v%0d_err_cnt", i),   bus.err_cnt, e_errs);
      check($sformatf("v%0d_ack_data", i),  bus.ack_data, e_ack);
      check($sformatf("v%0d_ack_valid", i), bus.ack_valid, 1);
      @(negedge clk);
      check($sformatf("v%0d_wr_en_drop", i),  bus.wr_en, 0);
      check($sformatf("v%0d_ack_drop", i),    bus.ack_valid, 0);
    end

    // gap timer expiry after A5 07
    t0 = to_pulses;
    put(8'hA5);
    put(8'h07);
    n = 0;
    while (!bus.timeout && n < 7000) begin
      @(negedge clk);
      n++;
    end
    e_errs++;
    check("to_gap_cycles", n, 6450);
    check("to_err_cnt",    bus.err_cnt, e_errs);
    check("to_ack_valid",  bus.ack_valid, 0);
    repeat (2) @(negedge clk);
    check("to_pulse_count", to_pulses - t0, 1);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    e_frames++;
    check("to_next_wr_en",   bus.wr_en, 1);
    check("to_next_wr_addr", bus.wr_addr, 8'h01);
    check("to_next_wr_data", bus.wr_data, 16'h0002);

    // byte landing exactly on the gap limit is consumed
    t0 = to_pulses;
    put(8'hA5);
    repeat (6449) @(negedge clk);
    put(8'h33);
    put(8'h44);
    put(8'h55);
    if (CHK) put(8'hCC);
    e_frames++;
    check("lim_wr_en",     bus.wr_en, 1);
    check("lim_wr_addr",   bus.wr_addr, 8'h33);
    check("lim_wr_data",   bus.wr_data, 16'h4455);
    check("lim_err_cnt",   bus.err_cnt, e_errs);
    check("lim_no_timeout", to_pulses - t0, 0);

    // back-to-back frames with ack held off
    @(negedge clk);
    bus.ack_ready = 1'b0;
    w0 = wr_pulses;
    send_frame(8'h40, 8'h00, 8'h01, 8'h41);
    send_frame(8'h41, 8'h00, 8'h02, 8'h43);
    e_frames += 16'd2;
    repeat (3) @(negedge clk);
    check("b2b_wr_pulses", wr_pulses - w0, 2);
    check("b2b_wr_addr",   bus.wr_addr, 8'h41);
    check("b2b_wr_data",   bus.wr_data, 16'h0002);
    check("b2b_frame_cnt", bus.frame_cnt, e_frames);
    check("b2b_ack_valid", bus.ack_valid, 1);
    check("b2b_ack_data",  bus.ack_data, 8'h5A);
    bus.ack_ready = 1'b1;
    @(negedge clk);
    bus.ack_ready = 1'b0;
    check("b2b_ack_cleared", bus.ack_valid, 0);

    // new ack in the same cycle the pending one is accepted
    send_frame(8'h50, 8'h00, 8'h00, 8'h50);
    e_frames++;
    put(8'hA5);
    put(8'h51);
    put(8'h00);
    if (CHK) put(8'h01);
    bus.ack_ready = 1'b1;
    put(CHK ? 8'h99 : 8'h01);
    bus.ack_ready = 1'b0;
    if (CHK) begin
      e_errs++;
      e_ack = 8'hE1;
    end else begin
      e_frames++;
      e_ack = 8'h5A;
    end
    check("sc_ack_valid", bus.ack_valid, 1);
    check("sc_ack_data",  bus.ack_data, e_ack);
    check("sc_frame_cnt", bus.frame_cnt, e_frames);
    check("sc_err_cnt",   bus.err_cnt, e_errs);
    bus.ack_ready = 1'b1;
    @(negedge clk);
    check("sc_ack_cleared", bus.ack_valid, 0);

    // reset in the middle of a frame discards it
    put(8'hA5);
    put(8'h01);
    put(8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_wr_addr",   bus.wr_addr, 0);
    check("mr_wr_data",   bus.wr_data, 0);
    check("mr_frame_cnt", bus.frame_cnt, 0);
    check("mr_err_cnt",   bus.err_cnt, 0);
    check("mr_ack_data",  bus.ack_data, 0);
    check("mr_ack_valid", bus.ack_valid, 0);
    w0 = wr_pulses;
    put(8'h02);
    if (CHK) put(8'h03);
    repeat (2) @(negedge clk);
    check("mr_no_write",     wr_pulses - w0, 0);
    check("mr_no_ack",       bus.ack_valid, 0);
    check("mr_frame_cnt_after", bus.frame_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
